// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit.
//   - RISC-V conditional-branch funct3 encodings
//   - bit positions of the ALU {N,Z,C,V} flag vector
//   - control state type used by branch_resolve_unit
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam int unsigned NZCV_N = 3;
  localparam int unsigned NZCV_Z = 2;
  localparam int unsigned NZCV_C = 1;
  localparam int unsigned NZCV_V = 0;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator.
// Ports:
//   funct3  in  RISC-V branch funct3
//   is_jump in  jal/jalr: always taken, funct3 ignored
//   nzcv    in  {N,Z,C,V} flags from the ALU
//   taken   out branch outcome
//   illegal out funct3 010/011 on a non-jump (reported as not taken)
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       is_jump,
  input  logic [3:0] nzcv,
  output logic       taken,
  output logic       illegal
);

  logic flag_n, flag_z, flag_c, flag_v;

  assign flag_n = nzcv[NZCV_N];
  assign flag_z = nzcv[NZCV_Z];
  assign flag_c = nzcv[NZCV_C];
  assign flag_v = nzcv[NZCV_V];

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    if (is_jump) begin
      taken = 1'b1;
    end else begin
      case (funct3)
        BEQ:     taken = flag_z;
        BNE:     taken = ~flag_z;
        BLT:     taken = flag_n ^ flag_v;
        BGE:     taken = ~(flag_n ^ flag_v);
        // unsigned-compare mode: C means a >= b
        BLTU:    taken = ~flag_c;
        BGEU:    taken = flag_c;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit at the end of EX.
// Resolves a conditional branch or jump from ALU flags, checks it against the
// front-end prediction and, on a mispredict, raises a held redirect to fetch
// together with a one-cycle flush. Keeps saturating branch/mispredict counts.
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   br_valid/br_ready                request handshake
//   br_funct3, br_is_jump, br_nzcv   condition inputs
//   br_pc, br_target, br_pred_taken  PC, taken target, prediction
//   resolve_valid/resolve_taken      one-cycle resolution pulse and outcome
//   redirect_valid/ready, redirect_pc  held redirect to fetch
//   flush                            one-cycle kill of younger instructions
//   misalign_err, illegal_err        one-cycle error pulses
//   cnt_clear, branch_cnt, mispredict_cnt  statistics
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_funct3,
  input  logic             br_is_jump,
  input  logic [3:0]       br_nzcv,
  input  logic [XLEN-1:0]  br_pc,
  input  logic [XLEN-1:0]  br_target,
  input  logic             br_pred_taken,
  output logic             resolve_valid,
  output logic             resolve_taken,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic             misalign_err,
  output logic             illegal_err,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  state_e          state;
  logic            accept;
  logic            cond_taken;
  logic            cond_illegal;
  logic            misaligned;
  logic            start_redirect;
  logic            redirect_done;
  logic [XLEN-1:0] next_pc;

  branch_cond_eval u_cond (
    .funct3  (br_funct3),
    .is_jump (br_is_jump),
    .nzcv    (br_nzcv),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  // While a redirect is pending, a new request may only enter in the same
  // cycle fetch takes the redirect.
  assign br_ready = (state == ST_IDLE) || redirect_ready;
  assign accept   = br_valid && br_ready;

  assign next_pc        = cond_taken ? br_target : (br_pc + XLEN'(4));
  assign misaligned     = cond_taken && (br_target[1:0] != 2'b00);
  assign start_redirect = accept && (cond_taken != br_pred_taken) && !misaligned;
  assign redirect_done  = (state == ST_REDIRECT) && redirect_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      resolve_valid  <= 1'b0;
      resolve_taken  <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      misalign_err   <= 1'b0;
      illegal_err    <= 1'b0;
    end else begin
      resolve_valid <= accept;
      resolve_taken <= accept && cond_taken;
      misalign_err  <= accept && misaligned;
      illegal_err   <= accept && cond_illegal;
      flush         <= start_redirect;

      if (start_redirect) begin
        state          <= ST_REDIRECT;
        redirect_valid <= 1'b1;
        redirect_pc    <= next_pc;
      end else if (accept || redirect_done) begin
        state          <= ST_IDLE;
        redirect_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (cnt_clear) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (accept && (branch_cnt != '1)) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (start_redirect && (mispredict_cnt != '1)) begin
        mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a driver issues directed and
// random requests, pushing the expected resolution into a queue; a monitor on
// the falling edge pops and compares. A second instance with 2-bit counters
// shares the inputs to exercise counter saturation.
module tb_branch_resolve_unit;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            br_valid = 1'b0;
  logic [2:0]      br_funct3 = '0;
  logic            br_is_jump = 1'b0;
  logic [3:0]      br_nzcv = '0;
  logic [XLEN-1:0] br_pc = '0;
  logic [XLEN-1:0] br_target = '0;
  logic            br_pred_taken = 1'b0;
  logic            redirect_ready = 1'b0;
  logic            cnt_clear = 1'b0;

  logic            br_ready, resolve_valid, resolve_taken, redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush, misalign_err, illegal_err;
  logic [15:0]     branch_cnt, mispredict_cnt;

  logic            br_ready2, resolve_valid2, resolve_taken2, redirect_valid2;
  logic [XLEN-1:0] redirect_pc2;
  logic            flush2, misalign_err2, illegal_err2;
  logic [1:0]      branch_cnt2, mispredict_cnt2;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .br_valid(br_valid), .br_ready(br_ready),
    .br_funct3(br_funct3), .br_is_jump(br_is_jump), .br_nzcv(br_nzcv),
    .br_pc(br_pc), .br_target(br_target), .br_pred_taken(br_pred_taken),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .flush(flush), .misalign_err(misalign_err),
    .illegal_err(illegal_err), .cnt_clear(cnt_clear),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .br_valid(br_valid), .br_ready(br_ready2),
    .br_funct3(br_funct3), .br_is_jump(br_is_jump), .br_nzcv(br_nzcv),
    .br_pc(br_pc), .br_target(br_target), .br_pred_taken(br_pred_taken),
    .resolve_valid(resolve_valid2), .resolve_taken(resolve_taken2),
    .redirect_valid(redirect_valid2), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc2), .flush(flush2), .misalign_err(misalign_err2),
    .illegal_err(illegal_err2), .cnt_clear(cnt_clear),
    .branch_cnt(branch_cnt2), .mispredict_cnt(mispredict_cnt2)
  );

  typedef struct {
    logic        taken;
    logic        misalign;
    logic        illegal;
    logic        redirect;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  bit          m_pending = 1'b0;   // redirect outstanding after the last edge
  longint      m_cb = 0;           // resolved branches since clear (unbounded)
  longint      m_mc = 0;           // redirects since clear (unbounded)
  logic [31:0] held_pc = '0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // ALU flags for a - b: signed/eq modes use subtract flags, C = (a >= b).
  function automatic logic [3:0] alu_flags(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    logic n, z, c, v;
    d = a - b;
    n = d[31];
    z = (d == 32'd0);
    c = (a >= b);
    v = (a[31] != b[31]) && (d[31] != a[31]);
    return {n, z, c, v};
  endfunction

  // Outcome from the operand relation the branch is meant to test.
  function automatic logic ref_taken(input logic j, input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] b);
    if (j) return 1'b1;
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    int unsigned sel;
    sel = $urandom_range(0, 6);
    case (sel)
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      5: return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic cyc(input logic v, input logic [2:0] f3, input logic j,
                     input logic [3:0] nz, input logic tk, input logic [31:0] pc,
                     input logic [31:0] tgt, input logic pred, input logic rr,
                     input logic clr);
    logic  exp_ready, acc, mis, redir;
    exp_t  e;
    br_valid = v; br_funct3 = f3; br_is_jump = j; br_nzcv = nz;
    br_pc = pc; br_target = tgt; br_pred_taken = pred;
    redirect_ready = rr; cnt_clear = clr;
    #2;
    exp_ready = !m_pending || rr;
    chk("br_ready", br_ready, exp_ready);
    acc   = v && exp_ready;
    mis   = tk && (tgt[1:0] != 2'b00);
    redir = (tk != pred) && !mis;
    e.taken    = tk;
    e.misalign = mis;
    e.illegal  = !j && (f3 == 3'b010 || f3 == 3'b011);
    e.redirect = redir;
    e.pc       = tk ? tgt : pc + 32'd4;
    @(posedge clk);
    #1;
    if (acc) exp_q.push_back(e);
    m_pending = acc ? redir : (m_pending && !rr);
    m_cb = clr ? 0 : m_cb + (acc ? 1 : 0);
    m_mc = clr ? 0 : m_mc + ((acc && redir) ? 1 : 0);
  endtask

  task automatic idle(input logic rr, input logic clr);
    cyc(1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, rr, clr);
  endtask

  // Monitor: compares DUT outputs against the scoreboard on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) continue;
      chk("resolve_valid", resolve_valid, exp_q.size() != 0);
      chk("redirect_valid", redirect_valid, m_pending);
      chk("branch_cnt", branch_cnt, sat(m_cb, 16));
      chk("mispredict_cnt", mispredict_cnt, sat(m_mc, 16));
      chk("branch_cnt_w2", branch_cnt2, sat(m_cb, 2));
      chk("mispredict_cnt_w2", mispredict_cnt2, sat(m_mc, 2));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("resolve_taken", resolve_taken, e.taken);
        chk("misalign_err", misalign_err, e.misalign);
        chk("illegal_err", illegal_err, e.illegal);
        chk("flush", flush, e.redirect);
        if (e.redirect) begin
          chk("redirect_pc", redirect_pc, e.pc);
          held_pc = e.pc;
        end
      end else begin
        chk("flush_idle", flush, 1'b0);
        chk("err_idle", {misalign_err, illegal_err}, 2'b00);
        if (m_pending) chk("redirect_pc_held", redirect_pc, held_pc);
      end
    end
  end

  initial begin
    logic [31:0] a, b, pc, tgt, rnd;
    logic [2:0]  f3;
    logic        j;

    // reset state
    #3;
    chk("rst_outputs", {resolve_valid, redirect_valid, flush, misalign_err, illegal_err}, 5'b0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_counters", {branch_cnt, mispredict_cnt}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // beq taken, predicted taken: no redirect
    cyc(1, 3'b000, 0, 4'b0100, 1, 32'h100, 32'h140, 1, 0, 0);
    // blt taken, predicted not taken: redirect to target, held 3 cycles
    cyc(1, 3'b100, 0, 4'b1000, 1, 32'h200, 32'h180, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc(1, 3'b000, 0, 4'b0100, 1, 32'h900, 32'h940, 1, 0, 0);
    idle(1, 0);
    // bgeu not taken, predicted taken: pc+4 wraps to 0
    cyc(1, 3'b111, 0, 4'b0000, 0, 32'hFFFF_FFFC, 32'h40, 1, 0, 0);
    idle(0, 0);
    // redirect accepted together with a new request
    cyc(1, 3'b000, 0, 4'b0100, 1, 32'h500, 32'h540, 1, 1, 0);
    // jal to a misaligned target
    cyc(1, 3'b000, 1, 4'b0000, 1, 32'h300, 32'h302, 0, 0, 0);
    // illegal funct3 predicted taken: not taken, redirect to pc+4
    cyc(1, 3'b010, 0, 4'b0000, 0, 32'h400, 32'h480, 1, 0, 0);
    idle(1, 0);
    // clear concurrent with a resolve
    cyc(1, 3'b001, 0, 4'b0000, 1, 32'h600, 32'h640, 1, 0, 1);
    idle(0, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      a  = pick_operand();
      b  = ($urandom_range(0, 3) == 0) ? a : pick_operand();
      f3 = 3'($urandom_range(0, 7));
      j  = ($urandom_range(0, 7) == 0);
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      rnd = $urandom;
      tgt = {rnd[31:2], 2'b00};
      if ($urandom_range(0, 5) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      cyc(($urandom_range(0, 3) != 0), f3, j, alu_flags(a, b), ref_taken(j, f3, a, b),
          pc, tgt, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 40) == 0));
    end

    // reset asserted while a redirect is pending
    idle(1, 0);
    cyc(1, 3'b100, 0, 4'b1000, 1, 32'h200, 32'h180, 0, 0, 0);
    idle(0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_redirect_valid", redirect_valid, 1'b0);
    chk("midrst_flush_pulses", {flush, resolve_valid, misalign_err, illegal_err}, 4'b0);
    chk("midrst_redirect_pc", redirect_pc, 32'd0);
    chk("midrst_counters", {branch_cnt, mispredict_cnt, branch_cnt2, mispredict_cnt2}, 36'd0);
    chk("midrst_br_ready", br_ready, 1'b1);
    m_pending = 1'b0; m_cb = 0; m_mc = 0;
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc(1, 3'b101, 0, 4'b0000, 1, 32'h700, 32'h800, 0, 0, 0);
    idle(1, 0);
    idle(0, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumes the NZCV flags and result produced by the ALU for a conditional branch or jump.
- Decides taken / not-taken and compares the decision against the front-end prediction.
- On mispredict, issues a held redirect plus a one-cycle flush to fetch.
- Sits at the end of EX. It is the consumer side of the ALU flag interface and keeps saturating branch / mispredict statistics.

Parameters:
XLEN, 32, address/PC width
CNT_W, 16, width of each statistics counter

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
br_valid  in  1  branch/jump request valid
br_ready  out  1  unit can accept request this cycle
br_funct3  in  3  RISC-V branch funct3
br_is_jump  in  1  jal/jalr: unconditionally taken, funct3 ignored
br_nzcv  in  4  {N,Z,C,V} from ALU for this branch
br_pc  in  XLEN  PC of the branch
br_target  in  XLEN  computed taken target
br_pred_taken  in  1  front-end prediction
resolve_valid  out  1  one-cycle pulse: branch resolved
resolve_taken  out  1  actual outcome, valid with resolve_valid
redirect_valid  out  1  redirect request to fetch
redirect_ready  in  1  fetch accepts redirect
redirect_pc  out  XLEN  corrected fetch PC
flush  out  1  one-cycle pulse: kill younger instructions
misalign_err  out  1  one-cycle pulse: taken target not 4-byte aligned
illegal_err  out  1  one-cycle pulse: funct3 010/011 on a non-jump
cnt_clear  in  1  synchronous clear of both counters
branch_cnt  out  CNT_W  resolved branches, saturating
mispredict_cnt  out  CNT_W  redirects issued, saturating

Behaviour:
Flags contract:
- Signed and eq/ne conditions use flags from the ALU subtract mode.
- bltu/bgeu use flags from the ALU unsigned-compare mode, where C = (a >= b).

Condition table:
- 000 beq: Z
- 001 bne: !Z
- 100 blt: N^V
- 101 bge: !(N^V)
- 110 bltu: !C
- 111 bgeu: C
- 010/011: not taken, illegal_err pulse at T+1.

Handshake and timing:
- A request is accepted on br_valid & br_ready (cycle T). All decisions use inputs sampled at T.
- States:
  - IDLE: br_ready=1.
  - REDIRECT: br_ready=redirect_ready (a combinational path is permitted).
- At T+1:
  - resolve_valid=1 and resolve_taken=actual.
  - branch_cnt increments.
- Mispredict is actual != br_pred_taken.
- Target selection: if actual is taken, next PC = br_target; otherwise next PC = br_pc+4 (mod 2^XLEN, wraps).
- Misaligned target: when actual is taken and br_target[1:0] != 0, the unit pulses misalign_err at T+1. No redirect and no flush are issued, and mispredict_cnt is not incremented.
- Mispredict (not misaligned): at T+1, enter REDIRECT:
  - redirect_valid=1 and redirect_pc=next PC, both held stable until redirect_ready.
  - flush=1 only in the first REDIRECT cycle.
  - mispredict_cnt increments once.
- In REDIRECT, when redirect_ready=1:
  - Without a simultaneous accept: return to IDLE.
  - With a simultaneous accept of a new request: the new request is processed normally at the next cycle (REDIRECT re-entered if it also mispredicts, with a fresh flush pulse).
- In REDIRECT, when redirect_ready=0: no new request is accepted.
- Counters:
  - Saturate at all-ones.
  - cnt_clear has priority over an increment in the same cycle; the result is 0.
- Reset (asynchronous, any time including mid-redirect): state=IDLE; all outputs 0 (br_ready=1 after reset release); redirect_pc=0; counters=0. A pending redirect is dropped.

Decomposition:
- Package branch_pkg:
  - funct3 localparams (BEQ, BNE, BLT, BGE, BLTU, BGEU).
  - NZCV bit-index localparams.
  - State enum {ST_IDLE, ST_REDIRECT}.
- Sub-module branch_cond_eval: purely combinational, (funct3, is_jump, nzcv) -> (taken, illegal).
- The top holds the FSM, the output registers and the counters.

Test Plan:
- beq, nzcv=4'b0100, pred=1, pc=0x100, target=0x140 -> T+1: resolve_valid=1, taken=1, no redirect; branch_cnt=1.
- blt, nzcv=4'b1000, pred=0, pc=0x200, target=0x180 -> T+1: redirect_valid=1, redirect_pc=0x180, flush for 1 cycle. With redirect_ready held low 3 cycles: redirect_pc stable, br_ready=0, mispredict_cnt=1.
- bgeu, nzcv=4'b0000, pred=1, pc=0xFFFFFFFC -> redirect_pc=0x00000000 (wrap); then redirect_ready=1 with br_valid=1 the same cycle -> new request accepted; resolve_valid at next cycle.
- jal, target=0x302, pred=0 -> misalign_err pulse, no redirect, no flush; mispredict_cnt unchanged.
- funct3=010, pred=1 -> illegal_err pulse, taken=0, redirect_pc=pc+4.
- CNT_W=2: resolve 5 branches -> branch_cnt=3; cnt_clear concurrent with a resolve -> 0. Assert reset_n low mid-REDIRECT -> redirect_valid=0 immediately, counters=0.
